// File: rtl/keypad_encoder.sv
// Ten-key keypad encoder: synchronizes raw key lines, debounces a single pressed key,
// emits a one-cycle BCD strobe per accepted press and shifts it into a 3-digit register.
module keypad_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  keypad,
  input  logic        enablen,
  input  logic        clear_digits,
  output logic [3:0]  bcd_out,
  output logic        data_valid,
  output logic        loadn,
  output logic [11:0] digits
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, WAIT_RELEASE} state_t;

  localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_CYCLES);

  state_t      state;
  logic [9:0]  ks_meta;
  logic [9:0]  ks;
  logic [9:0]  cand;
  logic [3:0]  cnt;
  logic        one_hot;
  logic [3:0]  cand_bcd;

  assign one_hot = (ks != 10'd0) && ((ks & (ks - 10'd1)) == 10'd0);

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cand_bcd = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (cand[i]) cand_bcd = 4'(i);
    end
  end

  // Outputs are registered; data_valid/loadn are raised on the edge that enters PRESSED,
  // so the strobe is visible exactly while the FSM sits in PRESSED.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ks_meta    <= 10'd0;
      ks         <= 10'd0;
      cand       <= 10'd0;
      cnt        <= 4'd0;
      bcd_out    <= 4'd0;
      data_valid <= 1'b0;
      loadn      <= 1'b1;
      digits     <= 12'h000;
    end else begin
      ks_meta    <= keypad;
      ks         <= ks_meta;
      data_valid <= 1'b0;
      loadn      <= 1'b1;
      if (clear_digits) digits <= 12'h000;

      unique case (state)
        IDLE: begin
          cnt <= 4'd0;
          if (!enablen && one_hot) begin
            cand  <= ks;
            cnt   <= 4'd1;
            state <= DEBOUNCE;
          end
        end

        DEBOUNCE: begin
          if (enablen || ks != cand) begin
            cnt   <= 4'd0;
            state <= IDLE;
          end else if (cnt == CNT_MAX) begin
            bcd_out    <= cand_bcd;
            data_valid <= 1'b1;
            loadn      <= 1'b0;
            // A coincident clear wins first, then the new digit is shifted in.
            digits     <= clear_digits ? {8'h00, cand_bcd} : {digits[7:0], cand_bcd};
            cnt        <= 4'd0;
            state      <= PRESSED;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        PRESSED: begin
          cnt   <= 4'd0;
          state <= WAIT_RELEASE;
        end

        WAIT_RELEASE: begin
          if (ks != 10'd0) begin
            cnt <= 4'd0;
          end else if (cnt + 4'd1 == CNT_MAX) begin
            cnt   <= 4'd0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder: a sample-history model compared every cycle,
// plus directed scenarios with hand-computed latencies, codes and digit values.
module tb_keypad_encoder;

  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  keypad = 10'd0;
  logic        enablen = 1'b0;
  logic        clear_digits = 1'b0;
  logic [3:0]  bcd_out;
  logic        data_valid;
  logic        loadn;
  logic [11:0] digits;

  int n_checks = 0;
  int n_fail   = 0;
  int strobes  = 0;
  int load_low = 0;

  keypad_encoder #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .keypad(keypad), .enablen(enablen),
    .clear_digits(clear_digits), .bcd_out(bcd_out), .data_valid(data_valid),
    .loadn(loadn), .digits(digits)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: keeps the last two raw samples as the synchronized view, counts consecutive
  // qualifying samples of one candidate key, then counts zero samples to re-arm.
  logic [9:0]  m_s1, m_s2, m_ks, m_cand;
  logic [3:0]  exp_bcd;
  logic        exp_dv, exp_loadn;
  logic [11:0] exp_digits;
  int          run, zrun;
  bit          armed, skip;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_s1 = 0; m_s2 = 0; m_cand = 0; run = 0; zrun = 0; armed = 1; skip = 0;
        exp_bcd = 0; exp_dv = 0; exp_loadn = 1; exp_digits = 0;
      end else begin
        m_ks = m_s2;
        exp_dv = 0;
        exp_loadn = 1;
        if (clear_digits) exp_digits = 0;
        if (armed) begin
          if (enablen) run = 0;
          else if (run == 0) begin
            if ($countones(m_ks) == 1) begin m_cand = m_ks; run = 1; end
          end else if (m_ks != m_cand) run = 0;
          else if (run == DC) begin
            for (int i = 0; i < 10; i++) if (m_cand[i]) exp_bcd = 4'(i);
            exp_dv = 1;
            exp_loadn = 0;
            exp_digits = {exp_digits[7:0], exp_bcd};
            armed = 0; skip = 1; zrun = 0; run = 0;
          end else run++;
        end else if (skip) skip = 0;
        else if (m_ks != 0) zrun = 0;
        else begin
          zrun++;
          if (zrun == DC) armed = 1;
        end
        m_s2 = m_s1;
        m_s1 = keypad;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (!rst) begin
        check("dv_model", data_valid, exp_dv);
        check("loadn_model", loadn, exp_loadn);
        check("bcd_model", bcd_out, exp_bcd);
        check("digits_model", digits, exp_digits);
        if (data_valid) strobes++;
        if (!loadn) load_low++;
      end
    end
  end

  task automatic wait_strobe(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (data_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int n, s0, l0;
  logic [11:0] seq_digits [4] = '{12'h001, 12'h013, 12'h130, 12'h309};
  int          seq_keys   [4] = '{1, 3, 0, 9};

  initial begin
    idle_cycles(3);
    check("rst_bcd", bcd_out, 4'd0);
    check("rst_dv", data_valid, 1'b0);
    check("rst_loadn", loadn, 1'b1);
    check("rst_digits", digits, 12'h000);
    rst = 1'b0;
    idle_cycles(3);

    // Key 5 held 20 cycles: one strobe, 7 cycles after the press.
    s0 = strobes; l0 = load_low;
    keypad = 10'b0000100000;
    wait_strobe(20, n);
    check("k5_latency", n, 7);
    check("k5_bcd", bcd_out, 4'd5);
    check("k5_loadn", loadn, 1'b0);
    check("k5_digits", digits, 12'h005);
    idle_cycles(13);
    keypad = 10'd0;
    idle_cycles(15);
    check("k5_strobes", strobes - s0, 1);
    check("k5_loadn_width", load_low - l0, 1);

    // Standalone clear.
    clear_digits = 1'b1;
    idle_cycles(1);
    clear_digits = 1'b0;
    idle_cycles(1);
    check("clear_digits", digits, 12'h000);

    // Keys 1,3,0,9 with full release between.
    s0 = strobes;
    for (int k = 0; k < 4; k++) begin
      keypad = 10'd1 << seq_keys[k];
      wait_strobe(20, n);
      check("seq_latency", n, 7);
      check("seq_digits", digits, seq_digits[k]);
      idle_cycles(5);
      keypad = 10'd0;
      idle_cycles(12);
    end
    check("seq_strobes", strobes - s0, 4);

    // Chattering key 2 after a fresh reset.
    rst = 1'b1;
    idle_cycles(2);
    check("rst2_digits", digits, 12'h000);
    rst = 1'b0;
    idle_cycles(2);
    s0 = strobes;
    for (int i = 0; i < 30; i++) begin
      keypad = ((i / 2) % 2 == 0) ? 10'b0000000100 : 10'd0;
      idle_cycles(1);
    end
    keypad = 10'd0;
    idle_cycles(10);
    check("bounce_strobes", strobes - s0, 0);
    check("bounce_bcd", bcd_out, 4'd0);

    // Two keys at once, then release of key 7.
    s0 = strobes;
    keypad = 10'b0010010000;
    idle_cycles(20);
    check("multi_strobes", strobes - s0, 0);
    keypad = 10'b0000010000;
    wait_strobe(20, n);
    check("multi_latency", n, 7);
    check("multi_bcd", bcd_out, 4'd4);
    @(negedge clk);
    keypad = 10'd0;
    idle_cycles(15);

    // Disabled capture, then enable while key 8 is held.
    s0 = strobes;
    enablen = 1'b1;
    keypad = 10'b0100000000;
    idle_cycles(20);
    check("dis_strobes", strobes - s0, 0);
    enablen = 1'b0;
    wait_strobe(20, n);
    check("en_latency", n, DC + 1);
    check("en_bcd", bcd_out, 4'd8);
    @(negedge clk);
    enablen = 1'b1;
    idle_cycles(5);
    keypad = 10'd0;
    idle_cycles(15);
    enablen = 1'b0;
    check("en_strobes", strobes - s0, 1);

    // Reset mid-debounce, then a held key needs full debounce again.
    s0 = strobes;
    keypad = 10'b0000001000;
    idle_cycles(4);
    rst = 1'b1;
    #1;
    check("abort_dv", data_valid, 1'b0);
    check("abort_loadn", loadn, 1'b1);
    check("abort_bcd", bcd_out, 4'd0);
    check("abort_digits", digits, 12'h000);
    idle_cycles(3);
    rst = 1'b0;
    wait_strobe(20, n);
    check("rearm_latency", n, 7);
    check("rearm_bcd", bcd_out, 4'd3);
    check("rearm_strobes", strobes - s0, 0);
    @(negedge clk);
    keypad = 10'd0;
    idle_cycles(15);
    check("rearm_digits", digits, 12'h003);

    // Clear coinciding with the strobe edge of key 6.
    keypad = 10'b0001000000;
    idle_cycles(6);
    clear_digits = 1'b1;
    @(posedge clk);
    #1;
    check("clr_dv", data_valid, 1'b1);
    check("clr_digits", digits, 12'h006);
    check("clr_bcd", bcd_out, 4'd6);
    @(negedge clk);
    clear_digits = 1'b0;
    keypad = 10'd0;
    idle_cycles(15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
